// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch/decode instruction queue.
package cpu_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0;

  // One queued fetch result: instruction word plus the PC+1 that goes with it.
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pcinc;
  } fetch_entry_t;

endpackage

// File: rtl/fb_ctrl.sv
// Fetch buffer control: read/write pointers, occupancy count, and the
// flush > push/pop priority. InReady/OutValid come from registered state only.
module fb_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic                       out_ready,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic                       wr_en,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Handshake flags depend only on the occupancy register, so a full buffer
  // refuses a push even when decode pops in the same cycle.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // A flushed push must never reach storage.
  assign wr_en  = push & ~flush;
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

  // Next-state: flush empties the queue outright; otherwise pointers advance
  // on their own handshakes and the count follows the push/pop difference.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode. Holds fetched instruction/PC+1
// pairs, decouples decode stalls from fetch, and drops everything on a flush.
// DATA_W must match cpu_pkg::DATA_W since entries use the shared struct.
module fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic                     Flush,
  input  logic                     InValid,
  input  logic [DATA_W-1:0]        InInstr,
  input  logic [DATA_W-1:0]        InPCInc,
  output logic                     InReady,
  output logic                     OutValid,
  output logic [DATA_W-1:0]        OutInstr,
  output logic [DATA_W-1:0]        OutPCInc,
  input  logic                     OutReady,
  output logic [$clog2(DEPTH):0]   Count
);

  import cpu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  fetch_entry_t     head;

  fb_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (Clock),
    .rst_n     (nReset),
    .flush     (Flush),
    .in_valid  (InValid),
    .out_ready (OutReady),
    .in_ready  (InReady),
    .out_valid (OutValid),
    .wr_en     (wr_en),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (Count)
  );

  // Storage write: only the slot at the write pointer changes on an accepted push.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr].instr = InInstr;
      mem_d[wr_ptr].pcinc = InPCInc;
    end
  end

  // Entry storage, cleared on reset so the queue starts from a known image.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Head read with NOP gating so decode sees zeros whenever the queue is empty.
  always_comb begin
    head     = mem_q[rd_ptr];
    OutInstr = NOP_INSTR;
    OutPCInc = '0;
    if (OutValid) begin
      OutInstr = head.instr;
      OutPCInc = head.pcinc;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus randomized traffic against
// a queue-based reference model.
module tb_fetch_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              Clock = 1'b0;
  logic              nReset;
  logic              Flush;
  logic              InValid;
  logic [DATA_W-1:0] InInstr;
  logic [DATA_W-1:0] InPCInc;
  logic              InReady;
  logic              OutValid;
  logic [DATA_W-1:0] OutInstr;
  logic [DATA_W-1:0] OutPCInc;
  logic              OutReady;
  logic [2:0]        Count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: in-order queue of {instr, pcinc}.
  logic [63:0] model_q [$];

  fetch_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .Flush    (Flush),
    .InValid  (InValid),
    .InInstr  (InInstr),
    .InPCInc  (InPCInc),
    .InReady  (InReady),
    .OutValid (OutValid),
    .OutInstr (OutInstr),
    .OutPCInc (OutPCInc),
    .OutReady (OutReady),
    .Count    (Count)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, advance the model by the queue rules, sample after the edge.
  task automatic cycle(input logic fl, input logic iv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic ordy);
    bit push_ok;
    bit pop_ok;
    Flush    = fl;
    InValid  = iv;
    InInstr  = ins;
    InPCInc  = pc;
    OutReady = ordy;
    push_ok  = iv && (model_q.size() < DEPTH);
    pop_ok   = ordy && (model_q.size() > 0);
    @(posedge Clock);
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop_ok)  model_q.delete(0);
      if (push_ok) model_q.push_back({ins, pc});
    end
    #1;
  endtask

  task automatic idle_inputs();
    Flush = 0; InValid = 0; InInstr = '0; InPCInc = '0; OutReady = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nReset = 0;
    repeat (2) @(posedge Clock);
    #1;
    n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", Count); end
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b expected 0", OutValid); end
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready: got %b expected 1", InReady); end
    n_checks++; if (OutInstr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", OutInstr); end
    n_checks++; if (OutPCInc !== 32'h0) begin n_fail++; $display("FAIL reset_pcinc: got %h expected 0", OutPCInc); end
    #3 nReset = 1;
    model_q.delete();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_single_push();
    cycle(0, 1, 32'h11111111, 32'd1, 0);
    n_checks++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", OutValid); end
    n_checks++; if (OutInstr !== 32'h11111111) begin n_fail++; $display("FAIL single_instr: got %h expected 11111111", OutInstr); end
    n_checks++; if (OutPCInc !== 32'd1) begin n_fail++; $display("FAIL single_pcinc: got %h expected 1", OutPCInc); end
    n_checks++; if (Count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", Count); end
    cycle(0, 0, 32'h0, 32'h0, 1);
    n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL single_drain: got %0d expected 0", Count); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'hA000_0000 + i, 32'd100 + i, 0);
    n_checks++; if (Count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", Count); end
    n_checks++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL fill_inready: got %b expected 0", InReady); end
    cycle(0, 1, 32'hA000_0004, 32'd104, 0);
    n_checks++; if (Count !== 3'd4) begin n_fail++; $display("FAIL fill_overflow: got %0d expected 4", Count); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (OutInstr !== 32'hA000_0000 + i) begin
        n_fail++; $display("FAIL drain_order%0d: got %h expected %h", i, OutInstr, 32'hA000_0000 + i);
      end
      n_checks++;
      if (OutPCInc !== 32'd100 + i) begin
        n_fail++; $display("FAIL drain_pc%0d: got %0d expected %0d", i, OutPCInc, 100 + i);
      end
      cycle(0, 0, 32'h0, 32'h0, 1);
    end
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b expected 0", OutValid); end
    n_checks++; if (OutInstr !== 32'h0) begin n_fail++; $display("FAIL drain_empty_instr: got %h expected 0", OutInstr); end
  endtask

  task automatic test_back_to_back();
    cycle(0, 1, 32'h3000_0000, 32'd0, 0);
    cycle(0, 1, 32'h3000_0001, 32'd1, 0);
    n_checks++; if (Count !== 3'd2) begin n_fail++; $display("FAIL b2b_start: got %0d expected 2", Count); end
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (OutInstr !== 32'h3000_0000 + k) begin
        n_fail++; $display("FAIL b2b_order%0d: got %h expected %h", k, OutInstr, 32'h3000_0000 + k);
      end
      cycle(0, 1, 32'h3000_0000 + k + 2, k + 2, 1);
      n_checks++;
      if (Count !== 3'd2) begin n_fail++; $display("FAIL b2b_count%0d: got %0d expected 2", k, Count); end
    end
  endtask

  task automatic test_full_pushpop();
    cycle(0, 1, 32'h3000_000C, 32'd12, 0);
    cycle(0, 1, 32'h3000_000D, 32'd13, 0);
    n_checks++; if (Count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", Count); end
    cycle(0, 1, 32'hDEAD_BEEF, 32'd99, 1);
    n_checks++; if (Count !== 3'd3) begin n_fail++; $display("FAIL full_pp_count: got %0d expected 3", Count); end
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL full_pp_inready: got %b expected 1", InReady); end
    n_checks++; if (OutInstr !== 32'h3000_000B) begin n_fail++; $display("FAIL full_pp_head: got %h expected 3000000b", OutInstr); end
  endtask

  task automatic test_flush();
    n_checks++; if (Count !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got %0d expected 3", Count); end
    cycle(1, 1, 32'hB000_0000, 32'd7, 0);
    n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", Count); end
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", OutValid); end
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL flush_inready: got %b expected 1", InReady); end
    cycle(0, 0, 32'h0, 32'h0, 0);
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL flush_b0_valid: got %b expected 0", OutValid); end
    n_checks++; if (OutInstr !== 32'h0) begin n_fail++; $display("FAIL flush_b0_instr: got %h expected 0", OutInstr); end
  endtask

  task automatic test_async_reset();
    cycle(0, 1, 32'h5000_0000, 32'd50, 0);
    cycle(0, 1, 32'h5000_0001, 32'd51, 0);
    n_checks++; if (Count !== 3'd2) begin n_fail++; $display("FAIL areset_pre: got %0d expected 2", Count); end
    idle_inputs();
    #3 nReset = 0;
    #1;
    n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", Count); end
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", OutValid); end
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL areset_inready: got %b expected 1", InReady); end
    n_checks++; if (OutInstr !== 32'h0) begin n_fail++; $display("FAIL areset_instr: got %h expected 0", OutInstr); end
    model_q.delete();
    @(posedge Clock);
    #3 nReset = 1;
    @(posedge Clock);
    #1;
    cycle(0, 1, 32'hC000_0000, 32'd77, 0);
    n_checks++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL areset_c0_valid: got %b expected 1", OutValid); end
    n_checks++; if (OutInstr !== 32'hC000_0000) begin n_fail++; $display("FAIL areset_c0_instr: got %h expected c0000000", OutInstr); end
    n_checks++; if (Count !== 3'd1) begin n_fail++; $display("FAIL areset_c0_count: got %0d expected 1", Count); end
  endtask

  task automatic test_random();
    logic [63:0] head;
    bit          exp_valid;
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 9) == 0), $urandom_range(0, 1), $urandom, $urandom,
            ($urandom_range(0, 2) != 0));
      exp_valid = (model_q.size() != 0);
      head      = exp_valid ? model_q[0] : 64'h0;
      n_checks++;
      if (Count !== 3'(model_q.size())) begin
        n_fail++; $display("FAIL rand_count@%0d: got %0d expected %0d", n, Count, model_q.size());
      end
      n_checks++;
      if (OutValid !== exp_valid) begin
        n_fail++; $display("FAIL rand_valid@%0d: got %b expected %b", n, OutValid, exp_valid);
      end
      n_checks++;
      if (InReady !== (model_q.size() != DEPTH)) begin
        n_fail++; $display("FAIL rand_inready@%0d: got %b expected %b", n, InReady, model_q.size() != DEPTH);
      end
      n_checks++;
      if (OutInstr !== head[63:32]) begin
        n_fail++; $display("FAIL rand_instr@%0d: got %h expected %h", n, OutInstr, head[63:32]);
      end
      n_checks++;
      if (OutPCInc !== head[31:0]) begin
        n_fail++; $display("FAIL rand_pcinc@%0d: got %h expected %h", n, OutPCInc, head[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_full_pushpop();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction queue between the instruction fetch stage and the decode stage.
- Each entry holds one fetched instruction and its incremented PC.
- Decouples fetch from decode stalls with a valid/ready handshake on both sides.
- On a taken branch (Flush), all queued wrong-path instructions are discarded in a single cycle.

Parameters:
- DEPTH, 4: number of entries; power of two, >= 2.
- DATA_W, 32: width of the instruction and PC fields.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- Flush  in  1  taken-branch flush; discards all entries.
- InValid  in  1  fetch presents an instruction this cycle.
- InInstr  in  DATA_W  fetched instruction word.
- InPCInc  in  DATA_W  PC+1 of the fetched instruction.
- InReady  out  1  buffer can accept; low means fetch must stall.
- OutValid  out  1  head entry valid for decode.
- OutInstr  out  DATA_W  head instruction; 0 (NOP) when OutValid=0.
- OutPCInc  out  DATA_W  head PC+1; 0 when OutValid=0.
- OutReady  in  1  decode accepts the head this cycle.
- Count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr=0, rd_ptr=0, Count=0, all entries 0.
  - OutValid=0, InReady=1, OutInstr=OutPCInc=0.
- Push = InValid & InReady. Pop = OutValid & OutReady. Both are evaluated at the rising edge.
- InReady = (Count != DEPTH):
  - Registered-state function only; no combinational path from OutReady.
  - When full, a push is refused even if a pop occurs in the same cycle.
- OutValid = (Count != 0).
- OutInstr/OutPCInc are the head entry, gated to 0 when empty.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. No fall-through bypass when empty.
- Push only: write mem[wr_ptr], wr_ptr+1 mod DEPTH, Count+1.
- Pop only: rd_ptr+1 mod DEPTH, Count-1.
- Push and pop together (0 < Count < DEPTH): both pointers advance, Count unchanged.
- Push and pop together (Count == 0): pop impossible (OutValid=0), so the push proceeds normally.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Count tracks full/empty, so there is no pointer-compare ambiguity.
- Flush (highest priority, synchronous):
  - At the edge: wr_ptr=rd_ptr=0, Count=0.
  - A push in the same cycle is dropped.
  - A pop in the same cycle is still treated as consumed by decode (decode owns squashing it). The buffer ends empty regardless.
  - Storage contents need not be cleared.
- After Flush: InReady=1 and OutValid=0 from the next cycle.
- Reset mid-operation: immediate return to the reset state; in-flight handshakes are lost.
- InValid while InReady=0: ignored. Fetch must hold its PC (drives the fetch stage Stall).
- Illegal inputs: none. All combinations of Flush/InValid/OutReady are defined.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W constant.
  - NOP_INSTR = 32'h0.
  - typedef struct packed {logic [DATA_W-1:0] instr; logic [DATA_W-1:0] pcinc;} fetch_entry_t.
- Sub-module fb_ctrl:
  - Holds pointer/count state, push/pop/flush priority, InReady/OutValid generation.
  - Parameterised by DEPTH.
- The top level holds the fetch_entry_t storage array and output gating.

Test Plan:
1. Reset, then InValid=1 with InInstr=32'h11111111, InPCInc=1, OutReady=0 for 1 cycle -> next cycle OutValid=1, OutInstr=32'h11111111, OutPCInc=1, Count=1.
2. Push 4 entries (A0..A3), OutReady=0 -> Count=4, InReady=0. A 5th push (A4) is ignored. Draining yields A0,A1,A2,A3 in order, then OutValid=0 and OutInstr=0.
3. Count=2, push and pop each cycle for 10 cycles with sequential words -> Count stays 2, output order matches input order across pointer wrap.
4. Full (Count=4), InValid=1 and OutReady=1 in the same cycle -> one pop, push refused, Count=3, InReady=1 next cycle.
5. Count=3, Flush=1 with InValid=1 (B0) -> next cycle Count=0, OutValid=0, InReady=1. B0 never appears at the outputs.
6. Count=2, assert nReset=0 mid-cycle -> outputs go to reset values immediately, without waiting for a clock edge. After release, first push C0 appears after 1 edge.
